// File: rtl/hs_serializer.sv
// hs_serializer: C-PHY master-side HS transmit serializer.
// Takes one 7-symbol word (flip/rotation/polarity buses) per valid/ready
// handshake into a one-word holding buffer and shifts it out one 3-bit
// symbol {flip, rotation, polarity} per symbol clock, LSB first. The
// holding buffer refills while the current word shifts, so consecutive
// words go out with no gap.
// Optional feature: define HS_SER_UNDERRUN_DETECT_EN to build the sticky
// underrun detector; otherwise Underrun is tied low.
module hs_serializer #(
    parameter int         SYMS_PER_WORD = 7,
    parameter logic [2:0] IDLE_SYM      = 3'b000
) (
    input  logic                     TxSymClkHS,
    input  logic                     Rst,
    input  logic                     HSSerEn,
    input  logic [SYMS_PER_WORD-1:0] TxFlip,
    input  logic [SYMS_PER_WORD-1:0] TxRotation,
    input  logic [SYMS_PER_WORD-1:0] TxPolarity,
    input  logic                     TxWordValid,
    output logic                     TxWordReady,
    output logic [2:0]               SerSym,
    output logic                     SerSymValid,
    output logic                     WordDone,
    output logic                     Underrun
);

    localparam int CNT_W = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYMS_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FIRST_CNT = (SYMS_PER_WORD > 1) ? CNT_W'(1) : '0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [SYMS_PER_WORD-1:0][2:0]   w_in_word;
    logic [SYMS_PER_WORD-1:0][2:0]   r_hold;
    logic                            r_hold_full;
    logic [SYMS_PER_WORD-1:0][2:0]   r_shift;
    logic [SYMS_PER_WORD-1:0][2:0]   w_shift_next;
    logic [CNT_W-1:0]                r_sym_cnt;
    logic [CNT_W-1:0]                w_sym_cnt_next;
    logic [2:0]                      r_ser_sym;
    logic [2:0]                      w_ser_sym_next;
    logic                            r_ser_valid;
    logic                            w_ser_valid_next;
    logic                            r_word_done;
    logic                            w_word_done_next;
    logic                            w_accept;
    logic                            w_load;

    // Regroup the three per-bit buses into per-symbol triplets.
    genvar gi;
    generate
        for (gi = 0; gi < SYMS_PER_WORD; gi++) begin : g_pack
            assign w_in_word[gi] = {TxFlip[gi], TxRotation[gi], TxPolarity[gi]};
        end
    endgenerate

    // A new word can be taken only when the holding buffer is empty.
    assign TxWordReady = ~r_hold_full;
    assign w_accept    = TxWordValid & ~r_hold_full;

    assign SerSym      = r_ser_sym;
    assign SerSymValid = r_ser_valid;
    assign WordDone    = r_word_done;

    // Holding buffer: capture on accept, release on load (never both at once).
    always_ff @(posedge TxSymClkHS or posedge Rst) begin
        if (Rst) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold      <= w_in_word;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Next-state and next-output decode; r_word_done marks that the last
    // symbol of a word is currently on SerSym, so the next edge either
    // chains the buffered word or drops back to idle.
    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_sym_cnt_next   = r_sym_cnt;
        w_ser_sym_next   = IDLE_SYM;
        w_ser_valid_next = 1'b0;
        w_word_done_next = 1'b0;
        w_load           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sym_cnt_next = '0;
                if (HSSerEn && r_hold_full) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_word_done) begin
                    if (HSSerEn && r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_sym_cnt_next = '0;
                    end
                end else begin
                    w_ser_sym_next   = r_shift[r_sym_cnt];
                    w_ser_valid_next = 1'b1;
                    w_word_done_next = (r_sym_cnt == LAST_IDX);
                    if (r_sym_cnt != LAST_IDX) begin
                        w_sym_cnt_next = r_sym_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_sym_cnt_next = '0;
            end
        endcase
        // Loading presents symbol 0 straight from the holding buffer.
        if (w_load) begin
            w_state_next     = ST_SHIFT;
            w_shift_next     = r_hold;
            w_ser_sym_next   = r_hold[0];
            w_ser_valid_next = 1'b1;
            w_word_done_next = (SYMS_PER_WORD == 1);
            w_sym_cnt_next   = FIRST_CNT;
        end
    end

    // State, shift register, counter and registered serial outputs.
    always_ff @(posedge TxSymClkHS or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_sym_cnt   <= '0;
            r_ser_sym   <= IDLE_SYM;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_sym_cnt   <= w_sym_cnt_next;
            r_ser_sym   <= w_ser_sym_next;
            r_ser_valid <= w_ser_valid_next;
            r_word_done <= w_word_done_next;
        end
    end

`ifdef HS_SER_UNDERRUN_DETECT_EN
    logic r_underrun;

    // Sticky starvation flag: a word finished while enabled with nothing queued.
    always_ff @(posedge TxSymClkHS or posedge Rst) begin
        if (Rst) begin
            r_underrun <= 1'b0;
        end else if (!HSSerEn) begin
            r_underrun <= 1'b0;
        end else if (r_word_done && !r_hold_full) begin
            r_underrun <= 1'b1;
        end
    end

    assign Underrun = r_underrun;
`else
    assign Underrun = 1'b0;
`endif

endmodule

// File: tb/tb_hs_serializer.sv
// Testbench for hs_serializer: directed words with hand-computed symbol
// sequences plus a word-level reference model checked every cycle.
module tb_hs_serializer;

    localparam int N = 7;
`ifdef HS_SER_UNDERRUN_DETECT_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         vld = 1'b0;
    logic [N-1:0] flip = '0;
    logic [N-1:0] rot  = '0;
    logic [N-1:0] pol  = '0;
    logic         ready;
    logic [2:0]   sym;
    logic         sval;
    logic         done;
    logic         under;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hs_serializer dut (
        .TxSymClkHS (clk),
        .Rst        (rst),
        .HSSerEn    (en),
        .TxFlip     (flip),
        .TxRotation (rot),
        .TxPolarity (pol),
        .TxWordValid(vld),
        .TxWordReady(ready),
        .SerSym     (sym),
        .SerSymValid(sval),
        .WordDone   (done),
        .Underrun   (under)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a queued word, the word being sent and the index of
    // the symbol currently on the output (-1 when nothing is being sent).
    logic [N-1:0] m_hf, m_hr, m_hp;
    logic [N-1:0] m_cf, m_cr, m_cp;
    bit           m_full;
    int           m_pos;
    bit           m_under;
    bit           m_acc;
    bit           m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full  = 1'b0;
            m_pos   = -1;
            m_under = 1'b0;
        end else begin
            m_acc  = vld && !m_full;
            m_last = (m_pos == N - 1);
            if (UR_EN) begin
                if (!en) m_under = 1'b0;
                else if (m_last && !m_full) m_under = 1'b1;
            end
            if (m_pos < 0 || m_last) begin
                if (en && m_full) begin
                    m_cf = m_hf; m_cr = m_hr; m_cp = m_hp;
                    m_pos  = 0;
                    m_full = 1'b0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
            if (m_acc) begin
                m_hf = flip; m_hr = rot; m_hp = pol;
                m_full = 1'b1;
            end
        end
    end

    function automatic logic [2:0] model_sym();
        if (m_pos < 0) return 3'b000;
        return {m_cf[m_pos], m_cr[m_pos], m_cp[m_pos]};
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("SerSymValid", sval,  m_pos >= 0);
        chk("SerSym",      sym,   model_sym());
        chk("WordDone",    done,  m_pos == N - 1);
        chk("TxWordReady", ready, !m_full);
        chk("Underrun",    under, m_under);
    end

    // Offer one word; waits (bounded) for ready, holds valid for one edge.
    task automatic send(input logic [N-1:0] f, input logic [N-1:0] r, input logic [N-1:0] p);
        int t = 0;
        @(negedge clk);
        while (!ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", ready, 1);
        flip = f; rot = r; pol = p; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Compare n consecutive symbols against a packed list (symbol 0 in the LSBs).
    task automatic check_seq(input logic [41:0] exp, input int n, input bit gap);
        int t = 0;
        while (!sval && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("seq_start", sval, 1);
        for (int i = 0; i < n; i++) begin
            chk("seq_sym",   sym,  exp[3*i +: 3]);
            chk("seq_valid", sval, 1);
            chk("seq_done",  done, (i % N) == N - 1);
            @(negedge clk);
        end
        if (gap) chk("seq_end_valid", sval, 0);
    endtask

    // Hand-computed words and their symbol streams (symbol 0 in the LSBs).
    localparam logic [N-1:0] W1F = 7'b1100110, W1R = 7'b1010101, W1P = 7'b0110011;
    localparam logic [N-1:0] W2F = 7'b1001101, W2R = 7'b0110110, W2P = 7'b1110001;
    localparam logic [20:0]  W1S = {3'b110, 3'b101, 3'b011, 3'b000, 3'b110, 3'b101, 3'b011};
    localparam logic [20:0]  W2S = {3'b101, 3'b011, 3'b011, 3'b100, 3'b110, 3'b010, 3'b101};

    logic [N-1:0] tf [4];
    logic [N-1:0] tr [4];
    logic [N-1:0] tp [4];

    initial begin
        tf = '{7'h55, 7'h7F, 7'h00, 7'h31};
        tr = '{7'h2A, 7'h00, 7'h7F, 7'h4C};
        tp = '{7'h0F, 7'h70, 7'h41, 7'h13};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sym",   sym,   3'b000);
        chk("rst_valid", sval,  0);
        chk("rst_done",  done,  0);
        chk("rst_under", under, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready, 1);

        // Single word, then underrun behaviour on a starved stream
        en = 1'b1;
        send(W1F, W1R, W1P);
        check_seq({21'd0, W1S}, 7, 1'b1);
        chk("underrun_lone", under, UR_EN);
        en = 1'b0;
        @(negedge clk);
        chk("underrun_clear", under, 0);

        // Back-to-back: second word offered while the first shifts
        en = 1'b1;
        fork
            check_seq({W2S, W1S}, 14, 1'b1);
            begin
                send(W1F, W1R, W1P);
                send(W2F, W2R, W2P);
            end
        join
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Enable dropped at symbol 3: word completes, buffered word waits
        en = 1'b1;
        send(W1F, W1R, W1P);
        for (int t = 0; t < 20 && !sval; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drop_sym3", sym, 3'b000);
        en = 1'b0;
        send(W2F, W2R, W2P);
        repeat (12) @(negedge clk);
        chk("held_ready", ready, 0);
        chk("held_valid", sval,  0);
        en = 1'b1;
        @(negedge clk);
        chk("resume_valid", sval, 1);
        chk("resume_sym",   sym,  3'b101);
        repeat (10) @(negedge clk);

        // Word offered while disabled is accepted but not sent
        en = 1'b0;
        send(W2F, W2R, W2P);
        chk("dis_ready", ready, 0);
        repeat (4) @(negedge clk);
        chk("dis_valid", sval, 0);
        en = 1'b1;
        check_seq({21'd0, W2S}, 7, 1'b1);

        // Table of words streamed back-to-back (model-checked)
        for (int i = 0; i < 4; i++) send(tf[i], tr[i], tp[i]);
        repeat (20) @(negedge clk);

        // Reset asserted mid-word takes effect at once
        send(W2F, W2R, W2P);
        for (int t = 0; t < 20 && !sval; t++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", sval,  0);
        chk("midrst_sym",   sym,   3'b000);
        chk("midrst_done",  done,  0);
        chk("midrst_under", under, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
